wdf_sched: RTL and testbench

- Controller/scheduler for the 8-entry write data FIFO (WDF) in the memory controller.
- Accepts host write data, allocates a free WDF slot and writes the data into it.
- Accepts write commands from the command scheduler, then issues the WDF read exactly cfg_wl cycles later so data reaches dfi_data at DFI write latency.
- Frees the slot when its read is issued.

---
 rtl/mc_pkg.sv | 30 +++
 rtl/wdf_wl_wheel.sv | 30 +++
 rtl/wdf_sched.sv | 99 +++++++++
 tb/tb_wdf_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared types and constants for the write-data-FIFO scheduler.
// Slot states, wheel entry layout and the lowest-free slot picker.
package mc_pkg;
  localparam int SLOTS  = 8;
  localparam int PTR_W  = 3;
  localparam int DW     = 64;
  localparam int MAX_WL = 16;
  localparam int WL_W   = 5;
  localparam int IDX_W  = $clog2(MAX_WL);

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    FILLED = 2'd1,
    ISSUED = 2'd2
  } slot_st_e;

  typedef struct packed {
    logic             valid;
    logic [PTR_W-1:0] slot;
  } wheel_ent_t;

  // Scan from the top so the lowest set bit wins.
  function automatic logic [PTR_W-1:0] lowest_free(input logic [SLOTS-1:0] free_mask);
    logic [PTR_W-1:0] idx;
    idx = '0;
    for (int i = SLOTS-1; i >= 0; i--)
      if (free_mask[i]) idx = PTR_W'(i);
    return idx;
  endfunction
endpackage

// File: rtl/wdf_wl_wheel.sv
// Write-latency timing wheel: entries shift toward 0 every cycle; a command
// loads at index wl-1 so it reaches entry 0 exactly wl cycles after accept.
module wdf_wl_wheel
  import mc_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [IDX_W-1:0] load_idx,
  input  logic [PTR_W-1:0] load_slot,
  output logic             collision,
  output wheel_ent_t       head
);
  wheel_ent_t [MAX_WL-1:0] ent_q, ent_d, shf;

  always_comb begin
    shf = '0;
    for (int i = 0; i < MAX_WL-1; i++) shf[i] = ent_q[i+1];
    ent_d = shf;
    if (load) ent_d[load_idx] = '{valid: 1'b1, slot: load_slot};
  end

  // Occupied target after the shift means two reads would land in one cycle.
  assign collision = shf[load_idx].valid;
  assign head      = ent_q[0];

  always_ff @(posedge clk or posedge rst)
    if (rst) ent_q <= '0;
    else     ent_q <= ent_d;
endmodule

// File: rtl/wdf_sched.sv
// WDF slot scheduler: allocates slots to host write beats, and issues the
// WDF read for each write command cfg_wl cycles after it is accepted.
module wdf_sched
  import mc_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              hwd_valid,
  output logic              hwd_ready,
  input  logic [DW-1:0]     hwd_data,
  output logic [PTR_W-1:0]  hwd_slot,
  input  logic              wcmd_valid,
  output logic              wcmd_ready,
  input  logic [PTR_W-1:0]  wcmd_slot,
  input  logic [WL_W-1:0]   cfg_wl,
  output logic              wdf_wr,
  output logic [PTR_W-1:0]  wdf_wptr,
  output logic [DW-1:0]     wdf_data,
  output logic              wdf_rd,
  output logic [PTR_W-1:0]  wdf_rptr,
  input  logic              wdf_fir,
  output logic [PTR_W:0]    free_cnt,
  output logic              err
);
  slot_st_e [SLOTS-1:0] slot_q, slot_d;
  logic [SLOTS-1:0]     free_mask;
  logic                 hwd_acc, wcmd_acc, wcmd_ok, wl_bad, collision;
  logic [IDX_W-1:0]     wl_idx;
  wheel_ent_t           head;
  logic                 wr_q, wr_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [DW-1:0]        data_q, data_d;
  logic [PTR_W:0]       free_cnt_q, free_cnt_d;
  logic                 err_q, err_d;

  always_comb
    for (int i = 0; i < SLOTS; i++) free_mask[i] = (slot_q[i] == FREE);

  assign hwd_ready  = |free_mask;
  assign hwd_slot   = lowest_free(free_mask);
  assign hwd_acc    = hwd_valid && hwd_ready;

  // Out-of-range latency falls back to the deepest wheel position.
  assign wl_bad     = (cfg_wl == '0) || (cfg_wl > WL_W'(MAX_WL));
  assign wl_idx     = wl_bad ? IDX_W'(MAX_WL-1) : IDX_W'(cfg_wl - WL_W'(1));
  assign wcmd_ready = !collision;
  assign wcmd_acc   = wcmd_valid && wcmd_ready;
  assign wcmd_ok    = wcmd_acc && (slot_q[wcmd_slot] == FILLED);

  wdf_wl_wheel u_wheel (
    .clk       (clk),
    .rst       (rst),
    .load      (wcmd_ok),
    .load_idx  (wl_idx),
    .load_slot (wcmd_slot),
    .collision (collision),
    .head      (head)
  );

  // Free, issue and fill always touch distinct slots (ISSUED/FILLED/FREE).
  always_comb begin
    slot_d = slot_q;
    if (head.valid) slot_d[head.slot] = FREE;
    if (wcmd_ok)    slot_d[wcmd_slot] = ISSUED;
    if (hwd_acc)    slot_d[hwd_slot]  = FILLED;
    wr_d       = hwd_acc;
    wptr_d     = hwd_acc ? hwd_slot : wptr_q;
    data_d     = hwd_acc ? hwd_data : data_q;
    free_cnt_d = '0;
    for (int i = 0; i < SLOTS; i++)
      free_cnt_d = free_cnt_d + (PTR_W+1)'(slot_d[i] == FREE);
    err_d = err_q || wl_bad || wdf_fir || (wcmd_acc && !wcmd_ok);
  end

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      for (int i = 0; i < SLOTS; i++) slot_q[i] <= FREE;
      wr_q       <= 1'b0;
      wptr_q     <= '0;
      data_q     <= '0;
      free_cnt_q <= (PTR_W+1)'(SLOTS);
      err_q      <= 1'b0;
    end else begin
      slot_q     <= slot_d;
      wr_q       <= wr_d;
      wptr_q     <= wptr_d;
      data_q     <= data_d;
      free_cnt_q <= free_cnt_d;
      err_q      <= err_d;
    end

  assign wdf_wr   = wr_q;
  assign wdf_wptr = wptr_q;
  assign wdf_data = data_q;
  assign wdf_rd   = head.valid;
  assign wdf_rptr = head.slot;
  assign free_cnt = free_cnt_q;
  assign err      = err_q;
endmodule

// File: tb/tb_wdf_sched.sv
// Bench for wdf_sched: a slot/queue model checked every cycle plus directed
// scenarios with literal timing and data expectations.
module tb_wdf_sched;
  import mc_pkg::*;

  logic             clk = 1'b0, rst = 1'b1;
  logic             hwd_valid, hwd_ready, wcmd_valid, wcmd_ready, wdf_fir;
  logic [DW-1:0]    hwd_data, wdf_data;
  logic [PTR_W-1:0] hwd_slot, wcmd_slot, wdf_wptr, wdf_rptr;
  logic [WL_W-1:0]  cfg_wl;
  logic             wdf_wr, wdf_rd, err;
  logic [PTR_W:0]   free_cnt;

  always #5 clk = ~clk;

  wdf_sched dut (
    .clk(clk), .rst(rst), .hwd_valid(hwd_valid), .hwd_ready(hwd_ready),
    .hwd_data(hwd_data), .hwd_slot(hwd_slot), .wcmd_valid(wcmd_valid),
    .wcmd_ready(wcmd_ready), .wcmd_slot(wcmd_slot), .cfg_wl(cfg_wl),
    .wdf_wr(wdf_wr), .wdf_wptr(wdf_wptr), .wdf_data(wdf_data), .wdf_rd(wdf_rd),
    .wdf_rptr(wdf_rptr), .wdf_fir(wdf_fir), .free_cnt(free_cnt), .err(err)
  );

  int checks = 0, errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int cyc; int slot; logic [DW-1:0] data; } rd_rec_t;
  typedef struct { int due; int slot; } pend_t;
  rd_rec_t rd_log[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int wl_eff(input int wl);
    return (wl == 0 || wl > MAX_WL) ? MAX_WL : wl;
  endfunction

  // Model: slot states (0 free, 1 filled, 2 issued) and a list of pending
  // reads keyed by the cycle in which their wdf_rd must appear.
  initial begin : cmp
    int            m_st [SLOTS];
    pend_t         m_pend[$];
    bit            m_wr, m_err, rd_due, coll, hacc, wacc, wok;
    int            m_wptr, nfree, low, rd_slot, now;
    logic [DW-1:0] m_data;
    logic [DW-1:0] tbmem [SLOTS];
    m_wr = 0; m_err = 0; m_wptr = 0; m_data = '0;
    foreach (m_st[i]) m_st[i] = 0;
    forever begin
      @(negedge clk);
      now = cyc;
      if (rst) begin
        foreach (m_st[i]) m_st[i] = 0;
        m_pend.delete();
        m_wr = 0; m_err = 0;
      end
      nfree = 0; low = -1;
      for (int i = 0; i < SLOTS; i++)
        if (m_st[i] == 0) begin nfree++; if (low < 0) low = i; end
      rd_due = 0; rd_slot = 0; coll = 0;
      foreach (m_pend[i]) begin
        if (m_pend[i].due == now) begin rd_due = 1; rd_slot = m_pend[i].slot; end
        if (m_pend[i].due == now + wl_eff(int'(cfg_wl))) coll = 1;
      end
      chk("hwd_ready", 64'(hwd_ready), 64'(nfree > 0));
      if (nfree > 0) chk("hwd_slot", 64'(hwd_slot), 64'(low));
      chk("wcmd_ready", 64'(wcmd_ready), 64'(!coll));
      chk("wdf_wr", 64'(wdf_wr), 64'(m_wr));
      if (m_wr) begin
        chk("wdf_wptr", 64'(wdf_wptr), 64'(m_wptr));
        chk("wdf_data", wdf_data, m_data);
      end
      if (wdf_wr) tbmem[wdf_wptr] = wdf_data;
      chk("wdf_rd", 64'(wdf_rd), 64'(rd_due));
      if (rd_due) chk("wdf_rptr", 64'(wdf_rptr), 64'(rd_slot));
      if (wdf_rd && !rst) rd_log.push_back('{now, int'(wdf_rptr), tbmem[wdf_rptr]});
      chk("free_cnt", 64'(free_cnt), 64'(nfree));
      chk("err", 64'(err), 64'(m_err));
      if (!rst) begin
        hacc = hwd_valid && (nfree > 0);
        wacc = wcmd_valid && !coll;
        wok  = wacc && (m_st[wcmd_slot] == 1);
        if (wdf_fir || cfg_wl == 0 || cfg_wl > MAX_WL || (wacc && !wok)) m_err = 1;
        if (rd_due) begin
          m_st[rd_slot] = 0;
          for (int i = m_pend.size()-1; i >= 0; i--)
            if (m_pend[i].due == now) m_pend.delete(i);
        end
        if (wok) begin
          m_st[wcmd_slot] = 2;
          m_pend.push_back('{now + wl_eff(int'(cfg_wl)), int'(wcmd_slot)});
        end
        m_wr = hacc;
        if (hacc) begin m_st[low] = 1; m_wptr = low; m_data = hwd_data; end
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic idle(input int n); repeat (n) step(); endtask
  task automatic do_reset();
    rst = 1; hwd_valid = 0; wcmd_valid = 0; wdf_fir = 0;
    step(); step(); rst = 0;
  endtask
  task automatic put(input logic [DW-1:0] d);
    hwd_valid = 1; hwd_data = d; step(); hwd_valid = 0;
  endtask
  task automatic cmd(input int s, input int wl, output int e);
    cfg_wl = WL_W'(wl); wcmd_valid = 1; wcmd_slot = PTR_W'(s); step();
    e = cyc; wcmd_valid = 0;
  endtask
  task automatic chk_rd(input string name, input int idx, input int exp_cyc, input int exp_slot);
    if (idx < rd_log.size()) begin
      chk({name, "_cyc"}, 64'(rd_log[idx].cyc), 64'(exp_cyc));
      chk({name, "_slot"}, 64'(rd_log[idx].slot), 64'(exp_slot));
    end else chk({name, "_missing"}, 64'(rd_log.size()), 64'(idx + 1));
  endtask

  initial begin
    int e, e0, n0, c;
    bit got;
    hwd_valid = 0; hwd_data = '0; wcmd_valid = 0; wcmd_slot = '0; cfg_wl = 5'd4; wdf_fir = 0;
    step(); step();
    @(negedge clk);
    chk("rst_hwd_ready", 64'(hwd_ready), 64'd1);
    chk("rst_hwd_slot", 64'(hwd_slot), 64'd0);
    chk("rst_free_cnt", 64'(free_cnt), 64'd8);
    chk("rst_wr_rd", {62'd0, wdf_wr, wdf_rd}, 64'd0);
    chk("rst_ptrs", 64'({wdf_wptr, wdf_rptr}), 64'd0);
    chk("rst_data", wdf_data, 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    step(); rst = 0;

    // Fill all slots, then drain with wl=4.
    for (int k = 0; k < 8; k++) put(64'h11 * (k + 1));
    @(negedge clk);
    chk("fill_ready", 64'(hwd_ready), 64'd0);
    chk("fill_free_cnt", 64'(free_cnt), 64'd0);
    step();
    n0 = rd_log.size();
    for (int k = 0; k < 8; k++) begin cmd(k, 4, e); if (k == 0) e0 = e; end
    idle(8);
    for (int k = 0; k < 8; k++) begin
      chk_rd("drain", n0 + k, e0 + 3 + k, k);
      if (n0 + k < rd_log.size()) chk("drain_data", rd_log[n0+k].data, 64'h11 * (k + 1));
    end
    @(negedge clk); chk("drain_free_cnt", 64'(free_cnt), 64'd8); step();

    // Latency extremes.
    put(64'hA1); n0 = rd_log.size(); cmd(0, 1, e); idle(3);
    chk_rd("wl1", n0, e, 0);
    put(64'hA2); n0 = rd_log.size(); cmd(0, 16, e); idle(18);
    chk_rd("wl16", n0, e + 15, 0);

    // Collision: A at wl=5, B at wl=4 one cycle later must wait.
    put(64'hB1); put(64'hB2); n0 = rd_log.size();
    cmd(0, 5, e);
    cfg_wl = 5'd4; wcmd_valid = 1; wcmd_slot = 3'd1;
    @(negedge clk); chk("coll_blocked", 64'(wcmd_ready), 64'd0); step();
    @(negedge clk); chk("coll_free", 64'(wcmd_ready), 64'd1); step();
    wcmd_valid = 0; idle(8);
    chk_rd("coll_a", n0, e + 4, 0);
    chk_rd("coll_b", n0 + 1, e + 5, 1);

    // Command to a FREE slot.
    do_reset(); n0 = rd_log.size();
    cmd(3, 4, e);
    @(negedge clk); chk("badslot_err", 64'(err), 64'd1); step();
    idle(6); chk("badslot_no_rd", 64'(rd_log.size()), 64'(n0));
    do_reset();
    @(negedge clk); chk("err_cleared", 64'(err), 64'd0); step();
    wdf_fir = 1; step(); wdf_fir = 0;
    @(negedge clk); chk("fir_err", 64'(err), 64'd1); step();
    idle(4);
    @(negedge clk); chk("fir_sticky", 64'(err), 64'd1); step();

    // Illegal cfg_wl=0 behaves as the deepest latency and flags err.
    do_reset();
    put(64'hC1); n0 = rd_log.size(); cmd(0, 0, e); idle(18);
    chk_rd("wl0", n0, e + 15, 0);
    @(negedge clk); chk("wl0_err", 64'(err), 64'd1); step();
    cfg_wl = 5'd4;

    // Reuse of a freed slot while host data waits.
    do_reset();
    for (int k = 0; k < 8; k++) put(64'(k));
    cmd(2, 2, c);
    hwd_valid = 1; hwd_data = 64'hAB; got = 0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (hwd_ready) begin
        got = 1;
        chk("reuse_slot", 64'(hwd_slot), 64'd2);
        chk("reuse_cyc", 64'(cyc), 64'(c + 2));
      end
      step();
    end
    hwd_valid = 0;
    chk("reuse_got", 64'(got), 64'd1);
    @(negedge clk);
    chk("reuse_wr", 64'({wdf_wr, wdf_wptr}), 64'h0A);
    chk("reuse_data", wdf_data, 64'hAB);
    step();

    // Reset with commands in flight.
    do_reset();
    put(64'hD0); put(64'hD1); put(64'hD2);
    cmd(0, 8, e); cmd(1, 8, e); cmd(2, 8, e);
    n0 = rd_log.size();
    step(); rst = 1;
    @(negedge clk);
    chk("midrst_rd_wr", {62'd0, wdf_wr, wdf_rd}, 64'd0);
    chk("midrst_free_cnt", 64'(free_cnt), 64'd8);
    chk("midrst_out", {wdf_data[57:0], wdf_wptr, wdf_rptr}, 64'd0);
    chk("midrst_err", 64'(err), 64'd0);
    step(); rst = 0;
    idle(12);
    chk("midrst_no_rd", 64'(rd_log.size()), 64'(n0));
    @(negedge clk); chk("midrst_free_after", 64'(free_cnt), 64'd8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
endmodule
